// File: rtl/bf0_input_buffer.sv
// Input staging for the first butterfly stage: buffers the first half of each frame
// and presents it lane-by-lane alongside the matching second-half sample.
module bf0_input_buffer #(
    parameter int IN_DATA_W = 9,
    parameter int UNIT_SIZE = 16,
    parameter int HALF_CNT  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      valid_in,
    input  logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] input_real,
    input  logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] input_imag,
    output logic                                      valid_out,
    output logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] output_sr_real,
    output logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] output_sr_imag,
    output logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] output_org_real,
    output logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] output_org_imag,
    output logic                                      busy
);

    localparam int CNT_W = $clog2(2 * HALF_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

    typedef logic signed [UNIT_SIZE-1:0][IN_DATA_W-1:0] lanes_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    lanes_t           sr_real_q, sr_real_d;
    lanes_t           sr_imag_q, sr_imag_d;
    lanes_t           org_real_q, org_real_d;
    lanes_t           org_imag_q, org_imag_d;
    lanes_t           fifo_real_q [HALF_CNT];
    lanes_t           fifo_real_d [HALF_CNT];
    lanes_t           fifo_imag_q [HALF_CNT];
    lanes_t           fifo_imag_d [HALF_CNT];
    logic             pair_phase;

    // The shift register advances on every accepted cycle: FILL loads it, and in PAIR
    // each shift both pops the oldest entry and tops it up with data FILL later overwrites.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pair_phase  = (cnt_q >= CNT_HALF);
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        sr_real_d   = sr_real_q;
        sr_imag_d   = sr_imag_q;
        org_real_d  = org_real_q;
        org_imag_d  = org_imag_q;
        fifo_real_d = fifo_real_q;
        fifo_imag_d = fifo_imag_q;

        if (valid_in) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            for (int j = 0; j < HALF_CNT - 1; j++) begin
                fifo_real_d[j] = fifo_real_q[j+1];
                fifo_imag_d[j] = fifo_imag_q[j+1];
            end
            fifo_real_d[HALF_CNT-1] = input_real;
            fifo_imag_d[HALF_CNT-1] = input_imag;

            if (pair_phase) begin
                valid_d    = 1'b1;
                sr_real_d  = fifo_real_q[0];
                sr_imag_d  = fifo_imag_q[0];
                org_real_d = input_real;
                org_imag_d = input_imag;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            sr_real_q  <= '0;
            sr_imag_q  <= '0;
            org_real_q <= '0;
            org_imag_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            sr_real_q  <= sr_real_d;
            sr_imag_q  <= sr_imag_d;
            org_real_q <= org_real_d;
            org_imag_q <= org_imag_d;
        end
    end

    // NOTE: storage is deliberately left unreset; FILL always rewrites it before PAIR reads it.
    always_ff @(posedge clk) begin
        fifo_real_q <= fifo_real_d;
        fifo_imag_q <= fifo_imag_d;
    end

    assign valid_out       = valid_q;
    assign output_sr_real  = sr_real_q;
    assign output_sr_imag  = sr_imag_q;
    assign output_org_real = org_real_q;
    assign output_org_imag = org_imag_q;
    assign busy            = (cnt_q != '0);

endmodule

// File: tb/tb_bf0_input_buffer.sv
// Bench for bf0_input_buffer: randomized and directed frames checked every cycle
// against a frame-level model that records first-half samples by index.
module tb_bf0_input_buffer;

    localparam int W = 9;
    localparam int U = 16;
    localparam int H = 16;

    typedef logic signed [U-1:0][W-1:0] lanes_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   valid_in = 1'b0;
    lanes_t input_real = '0;
    lanes_t input_imag = '0;
    logic   valid_out;
    lanes_t output_sr_real, output_sr_imag, output_org_real, output_org_imag;
    logic   busy;

    int total = 0;
    int bad   = 0;

    // Model state: position in frame, first-half samples by index, expected held outputs.
    int     m_cnt = 0;
    lanes_t fill_r [H];
    lanes_t fill_i [H];
    logic   exp_valid = 1'b0;
    lanes_t exp_sr_r = '0, exp_sr_i = '0, exp_org_r = '0, exp_org_i = '0;
    int     pulses = 0;

    bf0_input_buffer #(.IN_DATA_W(W), .UNIT_SIZE(U), .HALF_CNT(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .input_real     (input_real),
        .input_imag     (input_imag),
        .valid_out      (valid_out),
        .output_sr_real (output_sr_real),
        .output_sr_imag (output_sr_imag),
        .output_org_real(output_org_real),
        .output_org_imag(output_org_imag),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic lanes_t rand_lanes();
        lanes_t l;
        for (int i = 0; i < U; i++) l[i] = W'($urandom);
        return l;
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        exp_valid = 1'b0;
        exp_sr_r  = '0;
        exp_sr_i  = '0;
        exp_org_r = '0;
        exp_org_i = '0;
    endtask

    // One clock: drive inputs, advance model, then sample outputs 1 time unit after the edge.
    task automatic do_cycle(input bit v, input lanes_t r, input lanes_t im);
        valid_in   = v;
        input_real = r;
        input_imag = im;
        exp_valid  = 1'b0;
        if (v) begin
            if (m_cnt < H) begin
                fill_r[m_cnt] = r;
                fill_i[m_cnt] = im;
            end else begin
                exp_valid = 1'b1;
                exp_sr_r  = fill_r[m_cnt-H];
                exp_sr_i  = fill_i[m_cnt-H];
                exp_org_r = r;
                exp_org_i = im;
            end
            m_cnt = (m_cnt + 1) % (2 * H);
        end
        @(posedge clk);
        #1;
        total++;
        if (valid_out !== exp_valid) begin
            bad++;
            $display("FAIL valid_out: got %b want %b (t=%0t)", valid_out, exp_valid, $time);
        end
        total++;
        if (busy !== (m_cnt != 0)) begin
            bad++;
            $display("FAIL busy: got %b want %b (t=%0t)", busy, (m_cnt != 0), $time);
        end
        total++;
        if ({output_sr_real, output_sr_imag, output_org_real, output_org_imag} !==
            {exp_sr_r, exp_sr_i, exp_org_r, exp_org_i}) begin
            bad++;
            $display("FAIL data: got sr_r=%h org_r=%h want sr_r=%h org_r=%h (t=%0t)",
                     output_sr_real, output_org_real, exp_sr_r, exp_org_r, $time);
            $display("FAIL data_imag: got sr_i=%h org_i=%h want sr_i=%h org_i=%h",
                     output_sr_imag, output_org_imag, exp_sr_i, exp_org_i);
        end
        if (valid_out === 1'b1) pulses++;
    endtask

    task automatic check_pulses(input string name, input int want);
        total++;
        if (pulses !== want) begin
            bad++;
            $display("FAIL %s pulses: got %0d want %0d", name, pulses, want);
        end
        pulses = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({valid_out, busy, output_sr_real, output_sr_imag, output_org_real, output_org_imag} !== '0) begin
            bad++;
            $display("FAIL %s: outputs not cleared, valid=%b busy=%b sr_r=%h org_r=%h",
                     name, valid_out, busy, output_sr_real, output_org_real);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        do_cycle(1'b0, '0, '0);
        pulses = 0;
    endtask

    // Lane i of cycle c carries c*16+i and its negation.
    task automatic test_sequential(input bit gaps);
        lanes_t r, im;
        for (int c = 0; c < 2 * H; c++) begin
            for (int i = 0; i < U; i++) begin
                r[i]  = W'(c * 16 + i);
                im[i] = W'(-(c * 16 + i));
            end
            do_cycle(1'b1, r, im);
            if (gaps) do_cycle(1'b0, rand_lanes(), rand_lanes());
        end
        do_cycle(1'b0, '0, '0);
        check_pulses(gaps ? "gapped_frame" : "sequential_frame", H);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4 * H; c++) do_cycle(1'b1, rand_lanes(), rand_lanes());
        do_cycle(1'b0, '0, '0);
        check_pulses("back_to_back", 2 * H);
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c < 10; c++) do_cycle(1'b1, rand_lanes(), rand_lanes());
        rst = 1'b1;
        #1 check_reset_outputs("mid_frame_reset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 2 * H; c++) do_cycle(1'b1, rand_lanes(), rand_lanes());
        do_cycle(1'b0, '0, '0);
        check_pulses("after_reset_frame", H);
    endtask

    task automatic test_extreme();
        lanes_t pos, neg;
        for (int i = 0; i < U; i++) begin
            pos[i] = 9'sd255;
            neg[i] = -9'sd256;
        end
        for (int c = 0; c < 2 * H; c++) begin
            if (c % 2 == 0) do_cycle(1'b1, pos, neg);
            else            do_cycle(1'b1, neg, pos);
        end
        do_cycle(1'b0, '0, '0);
        check_pulses("extreme_values", H);
    endtask

    // Random gaps in both phases also exercise busy across partial frames.
    task automatic test_random_gaps();
        int accepted = 0;
        while (accepted < 4 * H) begin
            bit v = ($urandom_range(0, 2) != 0);
            do_cycle(v, rand_lanes(), rand_lanes());
            if (v) accepted++;
        end
        do_cycle(1'b0, '0, '0);
        check_pulses("random_gaps", 2 * H);
    endtask

    initial begin
        test_reset();
        test_sequential(1'b0);
        test_sequential(1'b1);
        test_back_to_back();
        test_reset_mid_frame();
        test_extreme();
        test_random_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf0_input_buffer.md
BF0_INPUT_BUFFER -- requirements
Module: bf0_input_buffer

Interface
REQ-001 SHALL have parameter IN_DATA_W, default 9, meaning the signed sample width of each real and imag component.
REQ-002 SHALL have parameter UNIT_SIZE, default 16, meaning the number of complex lanes per cycle.
REQ-003 SHALL have parameter HALF_CNT, default 16, meaning the cycles per half-frame (frame = 2*HALF_CNT accepted cycles).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid_in  input  1  input lanes carry a sample this cycle.
REQ-007 SHALL have port input_real  input  UNIT_SIZE x IN_DATA_W signed  real part per lane.
REQ-008 SHALL have port input_imag  input  UNIT_SIZE x IN_DATA_W signed  imag part per lane.
REQ-009 SHALL have port valid_out  output  1  the sr/org outputs form a valid butterfly pair.
REQ-010 SHALL have port output_sr_real  output  UNIT_SIZE x IN_DATA_W signed  delayed (first-half) real, per lane.
REQ-011 SHALL have port output_sr_imag  output  UNIT_SIZE x IN_DATA_W signed  delayed (first-half) imag, per lane.
REQ-012 SHALL have port output_org_real  output  UNIT_SIZE x IN_DATA_W signed  current (second-half) real, per lane.
REQ-013 SHALL have port output_org_imag  output  UNIT_SIZE x IN_DATA_W signed  current (second-half) imag, per lane.
REQ-014 SHALL have port busy  output  1  a frame is partially received (frame counter != 0).

Function
REQ-015 SHALL keep a frame counter of width clog2(2*HALF_CNT) that increments only on cycles with valid_in=1, wrapping 2*HALF_CNT-1 -> 0.
REQ-016 SHALL treat counter values 0..HALF_CNT-1 as FILL phase and HALF_CNT..2*HALF_CNT-1 as PAIR phase.
REQ-017 SHALL, on a FILL cycle with valid_in=1, push all UNIT_SIZE lanes into a HALF_CNT-deep per-lane shift register (FIFO order) and leave valid_out=0 in the next cycle.
REQ-018 SHALL, on a PAIR cycle with valid_in=1, register the oldest shift-register entry to output_sr_*, register the current inputs to output_org_*, pop that entry, and assert valid_out in the next cycle (latency 1).
REQ-019 SHALL pair the k-th PAIR-phase input (k=0..HALF_CNT-1) with the k-th FILL-phase input of the same frame, lane by lane, with no arithmetic, sign change or width change.
REQ-020 SHALL, on cycles with valid_in=0, hold the counter, shift register and output data and drive valid_out=0 in the next cycle.
REQ-021 SHALL tolerate arbitrary valid_in gaps in either phase without loss or reordering of data.
REQ-022 SHALL begin FILL of the next frame on the cycle immediately after the last PAIR cycle, giving back-to-back frames 2*HALF_CNT valid cycles apart.
REQ-023 SHALL drive busy=1 whenever the counter is non-zero, and busy=0 otherwise.
REQ-024 SHALL produce exactly HALF_CNT valid_out pulses per completed frame, matching the HALF_CNT-cycle burst the downstream butterfly counts.

Reset
REQ-025 SHALL, while rst=1, asynchronously force the counter to 0, valid_out to 0, busy to 0, and all output_sr_*/output_org_* to 0.
REQ-026 SHALL not require shift-register storage to be reset; storage is always overwritten by FILL before it is read.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame and treat the first valid_in after release as FILL entry 0.

Verification
REQ-028 SHALL pass: 32 consecutive valid cycles, lane i of cycle c = c*16+i (real) and -(c*16+i) (imag) -> valid_out high on cycles 17..32 after the first input; the k-th pulse gives sr_real[i]=k*16+i and org_real[i]=(k+16)*16+i, with imag negated.
REQ-029 SHALL pass: the same frame with valid_in deasserted every other cycle -> identical 16 output pairs, valid_out never high in the cycle after a valid_in=0 cycle.
REQ-030 SHALL pass: two back-to-back frames (64 valid cycles) -> 32 valid_out pulses, with the second frame's pairs drawn only from the second frame's data.
REQ-031 SHALL pass: rst pulsed after 10 FILL cycles, then a full frame -> no valid_out before the new frame's 17th input, and pairs match the new frame only.
REQ-032 SHALL pass: extreme values (+255 and -256 on all lanes) -> outputs bit-exact to the inputs, with no saturation or sign error.
REQ-033 SHALL pass: busy check -> busy=1 from the first accepted valid_in until the 32nd accepted valid_in, then 0 in the following cycle.
